// File: rtl/cartoon_pkg.sv
// Shared types and constants for the cartoon filter pipeline.
// A pixel is {R,G,B}; a window frame holds nine pixels with element 8 as the top-left neighbour.
package cartoon_pkg;

    localparam int PIXEL_BITS = 24;
    localparam int FRAME_BITS = 216;

    typedef logic [2:0][7:0]  pixel_t;
    typedef logic [8:0][23:0] pixel_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } ws_state_t;

endpackage

// File: rtl/line_buffer.sv
// Two line stores sharing one column address: lb0 holds row-2 and lb1 holds row-1.
// Reads see the old contents; the write shifts lb1 into lb0 and the new pixel into lb1.
module line_buffer
    import cartoon_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [PIXEL_BITS-1:0] wr_data,
    output logic [PIXEL_BITS-1:0] rd_top,
    output logic [PIXEL_BITS-1:0] rd_mid
);

    pixel_t lb0 [DEPTH];
    pixel_t lb1 [DEPTH];

    assign rd_top = lb0[addr];
    assign rd_mid = lb1[addr];

    // Contents are never reset; stale columns are masked by the emission rule upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb0[addr] <= lb1[addr];
            lb1[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Raster-scan 3x3 window generator: emits the full neighbourhood of every interior
// pixel one clock after the pixel completing that neighbourhood is accepted.
module window_gen
    import cartoon_pkg::*;
#(
    parameter int MAX_WIDTH = 640,
    parameter int DIM_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic [DIM_BITS-1:0]   image_width,
    input  logic [DIM_BITS-1:0]   image_height,
    input  logic                  in_valid,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    output logic                  in_ready,
    output logic [FRAME_BITS-1:0] pixelData,
    output logic                  frame_valid,
    output logic [DIM_BITS-1:0]   win_row,
    output logic [DIM_BITS-1:0]   win_col,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err
);

    ws_state_t                   state;
    logic [DIM_BITS-1:0]         row, col, width, height;
    logic [PIXEL_BITS-1:0]       rd_top, rd_mid;
    logic [2:0][PIXEL_BITS-1:0]  col1, col2;
    pixel_frame_t                win;
    logic                        accept, dims_ok, store, emit, last_col, last_row;

    assign accept   = in_valid && in_ready && !clear;
    assign dims_ok  = (image_width >= DIM_BITS'(3)) && (image_height >= DIM_BITS'(3)) &&
                      (int'(image_width) <= MAX_WIDTH);
    assign store    = accept && ((state == RUN) || ((state == IDLE) && dims_ok));
    assign emit     = accept && (state == RUN) && (row >= DIM_BITS'(2)) && (col >= DIM_BITS'(2));
    assign last_col = (col == width - DIM_BITS'(1));
    assign last_row = (row == height - DIM_BITS'(1));

    line_buffer #(
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (DIM_BITS)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (store),
        .addr    (col),
        .wr_data (in_pixel),
        .rd_top  (rd_top),
        .rd_mid  (rd_mid)
    );

    // Left column is the oldest (col2), right column is the one arriving now.
    always_comb begin
        win = {col2[2], col1[2], rd_top,
               col2[1], col1[1], rd_mid,
               col2[0], col1[0], in_pixel};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col1      <= '0;
            col2      <= '0;
            pixelData <= '0;
        end else if (store) begin
            col2 <= col1;
            col1 <= {rd_top, rd_mid, in_pixel};
            if (emit) pixelData <= win;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            width       <= '0;
            height      <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                row      <= '0;
                col      <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b0;
                err      <= 1'b0;
            end else if (accept) begin
                case (state)
                    IDLE: begin
                        width  <= image_width;
                        height <= image_height;
                        if (dims_ok) begin
                            row   <= '0;
                            col   <= DIM_BITS'(1);
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (emit) begin
                            frame_valid <= 1'b1;
                            win_row     <= row - DIM_BITS'(1);
                            win_col     <= col - DIM_BITS'(1);
                        end
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row        <= '0;
                                state      <= IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + DIM_BITS'(1);
                            end
                        end else begin
                            col <= col + DIM_BITS'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen: drives raster frames and compares every emitted
// window (position, data, cycle, frame_done) against a neighbourhood model built from the image.
module tb_window_gen;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          clear = 1'b0;
    logic [DW-1:0] image_width = '0;
    logic [DW-1:0] image_height = '0;
    logic          in_valid = 1'b0;
    logic [23:0]   in_pixel = '0;
    logic          in_ready, frame_valid, frame_done, busy, err;
    logic [215:0]  pixelData;
    logic [DW-1:0] win_row, win_col;

    typedef struct {
        int           r;
        int           c;
        logic [215:0] d;
        bit           fd;
        int           cy;
    } win_t;

    win_t        obs_q[$];
    win_t        exp_q[$];
    logic [23:0] img [16][16];
    int          acc_cyc [16][16];
    int          cyc = 0;
    int          fd_count = 0;
    int          stall_errs = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    window_gen #(.MAX_WIDTH(640), .DIM_BITS(DW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .image_width  (image_width),
        .image_height (image_height),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_ready     (in_ready),
        .pixelData    (pixelData),
        .frame_valid  (frame_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .frame_done   (frame_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            win_t o;
            o.r  = int'(win_row);
            o.c  = int'(win_col);
            o.d  = pixelData;
            o.fd = (frame_done === 1'b1);
            o.cy = cyc;
            obs_q.push_back(o);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic fill_pattern();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = {8'(r), 8'(c), 8'hA5};
    endtask

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = 24'($urandom);
    endtask

    task automatic start_test();
        obs_q.delete();
        exp_q.delete();
        fd_count   = 0;
        stall_errs = 0;
    endtask

    // Every interior pixel's 3x3 neighbourhood, raster order, top-left neighbour in the MSBs.
    task automatic build_expected(input int w, input int h);
        for (int r = 1; r < h - 1; r++)
            for (int c = 1; c < w - 1; c++) begin
                win_t e;
                e.d = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        e.d = {e.d[191:0], img[r+dr][c+dc]};
                e.r  = r;
                e.c  = c;
                e.fd = (r == h - 2) && (c == w - 2);
                e.cy = acc_cyc[r+1][c+1];
                exp_q.push_back(e);
            end
    endtask

    // duty = percent chance of presenting a pixel each cycle; npix < 0 sends the whole frame.
    task automatic send_frame(input int w, input int h, input int duty, input int npix);
        int n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (npix >= 0 && n >= npix) begin
                    in_valid = 1'b0;
                    return;
                end
                if (duty < 100)
                    for (int b = 0; b < 20 && int'($urandom_range(99)) >= duty; b++) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                image_width  = DW'(w);
                image_height = DW'(h);
                in_valid     = 1'b1;
                in_pixel     = img[r][c];
                if (in_ready !== 1'b1) stall_errs++;
                @(posedge clk); #1;
                acc_cyc[r][c] = cyc;
                n++;
            end
        in_valid = 1'b0;
    endtask

    task automatic check_windows(input string name, input int n_frames);
        int n;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL %s window_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        else n_pass++;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d ||
                obs_q[i].fd !== exp_q[i].fd || obs_q[i].cy !== exp_q[i].cy)
                $display("FAIL %s window[%0d]: got (%0d,%0d) fd=%0d cyc=%0d data=%h expected (%0d,%0d) fd=%0d cyc=%0d data=%h",
                         name, i, obs_q[i].r, obs_q[i].c, obs_q[i].fd, obs_q[i].cy, obs_q[i].d,
                         exp_q[i].r, exp_q[i].c, exp_q[i].fd, exp_q[i].cy, exp_q[i].d);
            else n_pass++;
        end
        n_checks++;
        if (fd_count !== n_frames)
            $display("FAIL %s frame_done_count: got %0d expected %0d", name, fd_count, n_frames);
        else n_pass++;
        n_checks++;
        if (stall_errs !== 0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s idle_ready: got stalls=%0d busy=%b in_ready=%b expected 0/0/1",
                     name, stall_errs, busy, in_ready);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 ||
            err !== 1'b0 || win_row !== '0 || win_col !== '0 || pixelData !== '0)
            $display("FAIL %s: got rdy=%b fv=%b fd=%b busy=%b err=%b row=%0d col=%0d data=%h expected 1,0,...",
                     name, in_ready, frame_valid, frame_done, busy, err, win_row, win_col, pixelData);
        else n_pass++;
    endtask

    task automatic test_reset();
        #3 n_rst = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_continuous();
        start_test();
        fill_pattern();
        send_frame(5, 4, 100, -1);
        build_expected(5, 4);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0].r !== 1 || obs_q[0].c !== 1 ||
            obs_q[0].d[215:192] !== 24'h0000A5 || obs_q[0].d[119:96] !== 24'h0101A5 ||
            obs_q[0].d[23:0] !== 24'h0202A5)
            $display("FAIL first_window: got count=%0d expected (1,1) 0000A5/0101A5/0202A5", obs_q.size());
        else n_pass++;
        check_windows("continuous_5x4", 1);
    endtask

    task automatic test_random_bubbles();
        start_test();
        fill_pattern();
        send_frame(5, 4, int'($urandom_range(30, 60)), -1);
        build_expected(5, 4);
        check_windows("bubbles_5x4", 1);
        start_test();
        fill_random();
        send_frame(8, 6, int'($urandom_range(30, 60)), -1);
        build_expected(8, 6);
        check_windows("random_data_8x6", 1);
    endtask

    task automatic test_error_clear();
        start_test();
        image_width  = DW'(2);
        image_height = DW'(4);
        in_valid     = 1'b1;
        in_pixel     = 24'h123456;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || obs_q.size() !== 0)
            $display("FAIL err_width2: got err=%b rdy=%b busy=%b windows=%0d expected 1/0/0/0",
                     err, in_ready, busy, obs_q.size());
        else n_pass++;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++;
        if (err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL clear_from_err: got err=%b rdy=%b expected 0/1", err, in_ready);
        else n_pass++;
        image_width  = DW'(641);
        image_height = DW'(3);
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL err_width641: got err=%b rdy=%b expected 1/0", err, in_ready);
        else n_pass++;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        fill_random();
        send_frame(3, 3, 100, -1);
        build_expected(3, 3);
        check_windows("after_clear_3x3", 1);
    endtask

    task automatic test_clear_priority();
        start_test();
        fill_pattern();
        send_frame(5, 4, 100, 13);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL clear_midframe: got busy=%b rdy=%b expected 0/1", busy, in_ready);
        else n_pass++;
        start_test();
        send_frame(5, 4, 100, -1);
        build_expected(5, 4);
        check_windows("after_clear_5x4", 1);
    endtask

    task automatic test_reset_midframe();
        start_test();
        fill_pattern();
        send_frame(5, 4, 100, 12);
        #2 n_rst = 1'b0;
        #1 check_reset_outputs("reset_midframe");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        start_test();
        send_frame(5, 4, 100, -1);
        build_expected(5, 4);
        check_windows("after_reset_5x4", 1);
    endtask

    task automatic test_back_to_back();
        start_test();
        fill_pattern();
        send_frame(5, 4, 100, -1);
        build_expected(5, 4);
        send_frame(7, 3, 100, -1);
        build_expected(7, 3);
        check_windows("back_to_back", 2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_random_bubbles();
        test_error_clear();
        test_clear_priority();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
